// File: rtl/load_store_unit.sv
// Load/store initiator: turns byte/halfword/word requests into word-wide memory
// accesses, doing read-modify-write for sub-word stores and extending load data.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    // Handshake: req is taken only when busy=0 (IDLE); the transaction ends with
    // a single-cycle done (err qualified by done); req must be re-presented afterwards.
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, merge_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, err_q;
    logic        bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val, merged;

    assign bad = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad)                state_nxt = DONE;
                    else if (!we)           state_nxt = LOAD;
                    else if (size == 2'b10) state_nxt = WRITE;
                    else                    state_nxt = RMW_READ;
                end
            end
            LOAD:     state_nxt = DONE;
            RMW_READ: state_nxt = WRITE;
            WRITE:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        byte_sel = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        size_q  <= size;
                        we_q    <= we;
                        uns_q   <= unsigned_ld;
                        err_q   <= bad;
                    end
                end
                LOAD:     rdata   <= ld_val;
                RMW_READ: merge_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;
    assign mem_write = (state == WRITE) && we_q;
    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign mem_wdata = merged;
    assign dbg_state = state;

endmodule
